// File: rtl/fft_stage_sched_if.sv
// Control and address bundle between the radix-2 FFT sequencer and its
// surrounding loader, butterfly and working RAM.
//
// Handshake: start is a level sampled only while the sequencer is idle. busy is high
// from the cycle after start through the done pulse. rd_en is a one-cycle issue
// strobe with no back-pressure other than stall. wr_en follows each rd_en a fixed
// number of cycles later and is never held off.
interface fft_stage_sched_if #(
  parameter int N_LOG2 = 10
);
  localparam int SW = $clog2(N_LOG2);

  logic              start;
  logic              abort;
  logic              stall;
  logic              busy;
  logic              done;
  logic [SW-1:0]     stage;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr_a;
  logic [N_LOG2-1:0] rd_addr_b;
  logic [N_LOG2-2:0] tw_addr;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;

  modport master (
    output start, abort, stall,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, abort, stall,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_stage_sched.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with one shared
// butterfly. It issues the read/twiddle addresses and delays them to form write-back.
module fft_stage_sched #(
  parameter int N_LOG2   = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_stage_sched_if.slave     bus,
  output logic [1:0]           dbg_state
);
  localparam int NW = N_LOG2;
  localparam int KW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [KW-1:0] k;
  logic [SW-1:0] stage;
  logic          last_stage;
  logic          drained;
  logic          rd_en;

  logic [NW-1:0] kk, h_c, lowm, a_c, b_c;
  logic [KW-1:0] j_c, tw_c;

  logic [PIPE_LAT-1:0] dl_v;
  logic [PIPE_LAT-1:0] dl_older;
  logic [NW-1:0]       dl_a [PIPE_LAT];
  logic [NW-1:0]       dl_b [PIPE_LAT];

  assign last_stage = (stage == SW'(N_LOG2 - 1));

  // Only the entry retiring this cycle may still be valid when leaving DRAIN.
  always_comb begin
    dl_older = dl_v;
    dl_older[PIPE_LAT-1] = 1'b0;
  end
  assign drained = (dl_older == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; abort overrides everything, including start in IDLE.
  always_comb begin
    state_n = state;
    if (bus.abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state_n = S_ISSUE;
        S_ISSUE: if (!bus.stall && (&k)) state_n = S_DRAIN;
        S_DRAIN: if (drained) state_n = last_stage ? S_DONE : S_ISSUE;
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    rd_en    = (state == S_ISSUE) && !bus.stall;
    bus.busy = (state != S_IDLE);
    bus.done = (state == S_DONE);
  end

  assign dbg_state = state;

  // Butterfly counter and stage counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      stage <= '0;
    end else if (bus.abort || state == S_IDLE || state == S_DONE) begin
      k     <= '0;
      stage <= '0;
    end else if (state == S_ISSUE && !bus.stall) begin
      k <= k + 1'b1;
    end else if (state == S_DRAIN && drained && !last_stage) begin
      stage <= stage + 1'b1;
      k     <= '0;
    end
  end

  // A = k with a zero inserted at bit 'stage'; B is its partner 2^stage away.
  always_comb begin
    kk   = NW'(k);
    h_c  = NW'(1) << stage;
    lowm = h_c - 1'b1;
    a_c  = ((kk & ~lowm) << 1) | (kk & lowm);
    b_c  = a_c | h_c;
    j_c  = k & KW'(lowm);
    tw_c = j_c << (SW'(N_LOG2 - 1) - stage);
  end

  assign bus.stage     = stage;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = (state == S_ISSUE) ? a_c  : '0;
  assign bus.rd_addr_b = (state == S_ISSUE) ? b_c  : '0;
  assign bus.tw_addr   = (state == S_ISSUE) ? tw_c : '0;

  // Write-back delay line; abort drops every in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else begin
      dl_v[0] <= rd_en && !bus.abort;
      dl_a[0] <= bus.rd_addr_a;
      dl_b[0] <= bus.rd_addr_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_v[i] <= dl_v[i-1] && !bus.abort;
        dl_a[i] <= dl_a[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  assign bus.wr_en     = dl_v[PIPE_LAT-1];
  assign bus.wr_addr_a = dl_a[PIPE_LAT-1];
  assign bus.wr_addr_b = dl_b[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched: N=8 schedules (plain, stalled, aborted,
// reset mid-run) against hand-computed tables, plus an N=1024 completion-time run.
module tb_fft_stage_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_stage_sched_if #(.N_LOG2(3))  bus3 ();
  fft_stage_sched_if #(.N_LOG2(10)) bus10 ();
  logic [1:0] dbg3, dbg10;

  fft_stage_sched #(.N_LOG2(3), .PIPE_LAT(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .dbg_state(dbg3)
  );
  fft_stage_sched #(.N_LOG2(10), .PIPE_LAT(2)) dut10 (
    .clk(clk), .rst_n(rst_n), .bus(bus10), .dbg_state(dbg10)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Entries: {cycle[7:0], stage[1:0], a[2:0], b[2:0], tw[1:0]}
  logic [17:0] exp_q[$];
  logic [17:0] wr_q[$];
  logic [9:0]  tbl [12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_exp(input int c[12], input int n_rd, input int n_wr);
    for (int i = 0; i < n_rd; i++) exp_q.push_back({8'(c[i]), tbl[i]});
    for (int i = 0; i < n_wr; i++) wr_q.push_back({8'(c[i] + 2), 2'b00, tbl[i][7:2], 2'b00});
  endtask

  task automatic run3(input int stall_lo, input int stall_hi, input int abort_at,
                      input int spur, input int exp_done);
    int done_c;
    int end_c;
    logic [17:0] e;
    step();
    cyc = 0;
    bus3.start = 1'b1;
    bus3.abort = 1'b0;
    bus3.stall = 1'b0;
    done_c = -1;
    end_c  = (abort_at >= 0) ? abort_at : exp_done;
    for (int i = 0; i < 40; i++) begin
      step();
      bus3.start = (cyc == spur);
      bus3.stall = (cyc >= stall_lo) && (cyc <= stall_hi);
      bus3.abort = (cyc == abort_at);
      #1;
      chk("busy", {31'b0, bus3.busy}, {31'b0, (cyc <= end_c)});
      if (bus3.rd_en) begin
        if (exp_q.size() == 0) chk("rd_extra_cycle", cyc, 0);
        else begin
          e = exp_q.pop_front();
          chk("rd", {14'b0, 8'(cyc), bus3.stage, bus3.rd_addr_a, bus3.rd_addr_b, bus3.tw_addr},
              {14'b0, e});
        end
      end
      if (bus3.wr_en) begin
        if (wr_q.size() == 0) chk("wr_extra_cycle", cyc, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr", {14'b0, 8'(cyc), 2'b00, bus3.wr_addr_a, bus3.wr_addr_b, 2'b00}, {14'b0, e});
        end
      end
      if (bus3.done) begin
        chk("done_cycle", cyc, exp_done);
        done_c = cyc;
      end
    end
    bus3.start = 1'b0;
    bus3.abort = 1'b0;
    bus3.stall = 1'b0;
    chk("done_seen", done_c, exp_done);
    chk("rd_left", exp_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    exp_q.delete();
    wr_q.delete();
  endtask

  initial begin
    int rdn;
    int wrn;
    tbl = '{10'b00_000_001_00, 10'b00_010_011_00, 10'b00_100_101_00, 10'b00_110_111_00,
            10'b01_000_010_00, 10'b01_001_011_10, 10'b01_100_110_00, 10'b01_101_111_10,
            10'b10_000_100_00, 10'b10_001_101_01, 10'b10_010_110_10, 10'b10_011_111_11};
    bus3.start  = 1'b0; bus3.abort  = 1'b0; bus3.stall  = 1'b0;
    bus10.start = 1'b0; bus10.abort = 1'b0; bus10.stall = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'b0, bus3.busy},  0);
    chk("rst_done",  {31'b0, bus3.done},  0);
    chk("rst_rd_en", {31'b0, bus3.rd_en}, 0);
    chk("rst_wr_en", {31'b0, bus3.wr_en}, 0);
    chk("rst_stage", {30'b0, bus3.stage}, 0);
    chk("rst_addr",  {18'b0, bus3.rd_addr_a, bus3.rd_addr_b, bus3.tw_addr,
                      bus3.wr_addr_a, bus3.wr_addr_b}, 0);
    chk("rst_state", {30'b0, dbg3}, 0);
    rst_n = 1'b1;

    // Plain run with a start pulse during busy that must be ignored
    load_exp('{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16}, 12, 12);
    run3(100, 0, -1, 5, 19);

    // Stall on cycles 2..4
    load_exp('{1, 5, 6, 7, 10, 11, 12, 13, 16, 17, 18, 19}, 12, 12);
    run3(2, 4, -1, -1, 22);

    // Abort at cycle 8: reads up to 8, writes only those due by cycle 8
    load_exp('{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16}, 6, 4);
    run3(100, 0, 8, -1, -1);

    // Fresh start after abort restarts from stage 0
    load_exp('{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16}, 12, 12);
    run3(100, 0, -1, -1, 19);

    // start and abort together in IDLE: abort wins
    step();
    bus3.start = 1'b1;
    bus3.abort = 1'b1;
    step();
    bus3.start = 1'b0;
    bus3.abort = 1'b0;
    chk("sa_busy",  {31'b0, bus3.busy}, 0);
    chk("sa_state", {30'b0, dbg3}, 0);
    step();
    chk("sa_rd_en", {31'b0, bus3.rd_en}, 0);

    // Async reset at cycle 5 while a write is in flight
    step();
    cyc = 0;
    bus3.start = 1'b1;
    step();
    bus3.start = 1'b0;
    repeat (4) step();
    chk("pre_rst_busy", {31'b0, bus3.busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", {31'b0, bus3.wr_en}, 0);
    chk("arst_busy",  {31'b0, bus3.busy},  0);
    chk("arst_outs",  {22'b0, bus3.rd_en, bus3.done, bus3.stage, bus3.rd_addr_a,
                       bus3.tw_addr}, 0);
    chk("arst_waddr", {26'b0, bus3.wr_addr_a, bus3.wr_addr_b}, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_idle", {29'b0, bus3.wr_en, bus3.rd_en, bus3.busy}, 0);
    end

    // N=1024 run: done at 10*514+1
    step();
    cyc = 0;
    bus10.start = 1'b1;
    step();
    bus10.start = 1'b0;
    rdn = 0;
    wrn = 0;
    while (!bus10.done && cyc < 6000) begin
      if (bus10.rd_en) rdn++;
      if (bus10.wr_en) wrn++;
      step();
    end
    chk("n10_done_cycle", cyc, 5141);
    chk("n10_rd_count", rdn, 5120);
    chk("n10_wr_count", wrn, 5120);
    step();
    chk("n10_idle", {31'b0, bus10.busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
